// File: rtl/random_placement_reseed_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | random_placement_reseed_ctrl_pkg                                      |
// | Shared state encoding and default seed for the placement reseed ctrl. |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
package random_placement_reseed_ctrl_pkg;

   typedef enum logic [1:0] {
      RP_IDLE  = 2'd0,
      RP_DRAIN = 2'd1,
      RP_FLUSH = 2'd2,
      RP_SWAP  = 2'd3
   } rp_reseed_state_t;

   localparam logic [11:0] RP_SEED_INIT = 12'hA5C;

endpackage
`default_nettype wire

// File: rtl/random_placement_reseed_ctrl_period_counter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | reseed_period_counter                                                 |
// | Counts accesses and flags the access that completes a reseed period.  |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module reseed_period_counter #(
   parameter int PERIOD = 4096
) (
   input  logic clk,
   input  logic reset,
   input  logic inc,
   input  logic clear,
   output logic hit
);

   localparam int CW = (PERIOD > 1) ? $clog2(PERIOD) : 1;

   generate
      if (PERIOD == 0) begin : g_disabled
         logic w_unused;
         assign w_unused = ^{clk, reset, inc, clear};
         assign hit      = 1'b0;
      end else begin : g_enabled
         localparam logic [CW-1:0] c_last = CW'(PERIOD - 1);
         logic [CW-1:0] r_count;

         // Saturates at the last value; the hit it produces is what clears it.
         always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
               r_count <= '0;
            end else if (clear) begin
               r_count <= '0;
            end else if (inc && (r_count != c_last)) begin
               r_count <= r_count + 1'b1;
            end
         end

         assign hit = inc && (r_count == c_last);
      end
   endgenerate

endmodule
`default_nettype wire

// File: rtl/random_placement_reseed_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | random_placement_reseed_ctrl                                          |
// | Quiesces, flushes every set, then swaps the cache placement seed.     |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module random_placement_reseed_ctrl
   import random_placement_reseed_ctrl_pkg::*;
#(
   parameter int                   INDX_BITS     = 6,
   parameter int                   CONT_BITS     = 12,
   parameter int                   RESEED_PERIOD = 4096,
   parameter logic [CONT_BITS-1:0] SEED_INIT     = CONT_BITS'(RP_SEED_INIT)
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 reseed_req,
   input  logic                 access_valid,
   input  logic                 mem_idle,
   input  logic [CONT_BITS-1:0] prng_i,
   output logic                 flush_valid,
   output logic [INDX_BITS-1:0] flush_set,
   input  logic                 flush_ready,
   output logic [CONT_BITS-1:0] seed_o,
   output logic                 stall_o,
   output logic                 reseed_done
);

   rp_reseed_state_t     r_state;
   rp_reseed_state_t     w_next_state;
   logic [INDX_BITS-1:0] r_flush_set;
   logic [CONT_BITS-1:0] r_seed;
   logic                 r_done;
   logic                 w_idle;
   logic                 w_period_hit;
   logic                 w_trigger;
   logic                 w_last_set;

   assign w_idle     = (r_state == RP_IDLE);
   assign w_trigger  = w_idle && (reseed_req || w_period_hit);
   assign w_last_set = &r_flush_set;

   // Held clear outside IDLE so accesses during a reseed never count.
   reseed_period_counter #(
      .PERIOD (RESEED_PERIOD)
   ) u_period_counter (
      .clk   (clk),
      .reset (reset),
      .inc   (access_valid),
      .clear (w_trigger || !w_idle),
      .hit   (w_period_hit)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= RP_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         RP_IDLE:  if (w_trigger) w_next_state = RP_DRAIN;
         RP_DRAIN: if (mem_idle) w_next_state = RP_FLUSH;
         RP_FLUSH: if (flush_ready && w_last_set) w_next_state = RP_SWAP;
         RP_SWAP:  w_next_state = RP_IDLE;
         default:  w_next_state = RP_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_flush_set <= '0;
         r_seed      <= SEED_INIT;
         r_done      <= 1'b0;
      end else begin
         r_done <= (r_state == RP_SWAP);
         case (r_state)
            RP_DRAIN: if (mem_idle) r_flush_set <= '0;
            RP_FLUSH: if (flush_ready) r_flush_set <= r_flush_set + 1'b1;
            // Forcing a change guarantees every reseed really remaps addresses.
            RP_SWAP:  r_seed <= (prng_i == r_seed) ? (prng_i ^ CONT_BITS'(1)) : prng_i;
            default:  ;
         endcase
      end
   end

   assign flush_valid = (r_state == RP_FLUSH);
   assign flush_set   = r_flush_set;
   assign seed_o      = r_seed;
   assign stall_o     = !w_idle;
   assign reseed_done = r_done;

endmodule
`default_nettype wire

// File: tb/tb_random_placement_reseed_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_random_placement_reseed_ctrl                                       |
// | Directed self-checking bench for the placement reseed controller.     |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module tb_random_placement_reseed_ctrl;

   logic        clk;
   logic        reset;
   logic        reseed_req;
   logic        access_valid;
   logic        mem_idle;
   logic [11:0] prng_i;
   logic        flush_valid;
   logic [5:0]  flush_set;
   logic        flush_ready;
   logic [11:0] seed_o;
   logic        stall_o;
   logic        reseed_done;

   int          checks   = 0;
   int          failures = 0;
   logic [11:0] exp_seed = 12'hA5C;

   random_placement_reseed_ctrl #(
      .INDX_BITS     (6),
      .CONT_BITS     (12),
      .RESEED_PERIOD (8),
      .SEED_INIT     (12'hA5C)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .reseed_req   (reseed_req),
      .access_valid (access_valid),
      .mem_idle     (mem_idle),
      .prng_i       (prng_i),
      .flush_valid  (flush_valid),
      .flush_set    (flush_set),
      .flush_ready  (flush_ready),
      .seed_o       (seed_o),
      .stall_o      (stall_o),
      .reseed_done  (reseed_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Called in the DRAIN cycle with mem_idle=1; returns in the SWAP cycle.
   task automatic walk_flush(input string tag);
      for (int k = 0; k < 64; k++) begin
         step();
         checks++;
         if (flush_valid !== 1'b1 || flush_set !== 6'(k)) begin
            failures++;
            $display("FAIL %s_walk set %0d: valid=%b set=%0d expected valid=1 set=%0d", tag, k, flush_valid, flush_set, k);
         end
      end
      step();
   endtask

   task automatic test_reset();
      reset = 1'b1; reseed_req = 1'b0; access_valid = 1'b0;
      mem_idle = 1'b0; flush_ready = 1'b0; prng_i = 12'h123;
      repeat (3) step();
      checks++;
      if (seed_o !== 12'hA5C || stall_o !== 1'b0 || flush_valid !== 1'b0 ||
          reseed_done !== 1'b0 || flush_set !== 6'd0) begin
         failures++;
         $display("FAIL reset_values: seed=%h stall=%b fv=%b done=%b set=%0d expected a5c/0/0/0/0", seed_o, stall_o, flush_valid, reseed_done, flush_set);
      end
      reset = 1'b0;
      repeat (2) step();
      checks++;
      if (stall_o !== 1'b0 || reseed_done !== 1'b0 || seed_o !== 12'hA5C) begin
         failures++;
         $display("FAIL post_reset_idle: stall=%b done=%b seed=%h expected 0/0/a5c", stall_o, reseed_done, seed_o);
      end
   endtask

   task automatic test_reseed_basic();
      mem_idle = 1'b1; flush_ready = 1'b1; reseed_req = 1'b1;
      checks++;
      if (stall_o !== 1'b0) begin
         failures++;
         $display("FAIL trigger_cycle_stall: stall=%b expected 0", stall_o);
      end
      step();
      reseed_req = 1'b0;
      checks++;
      if (stall_o !== 1'b1 || flush_valid !== 1'b0) begin
         failures++;
         $display("FAIL drain_state: stall=%b fv=%b expected 1/0", stall_o, flush_valid);
      end
      walk_flush("basic");
      prng_i = 12'h3C7;
      checks++;
      if (flush_valid !== 1'b0 || stall_o !== 1'b1 || flush_set !== 6'd0 || reseed_done !== 1'b0) begin
         failures++;
         $display("FAIL swap_state: fv=%b stall=%b set=%0d done=%b expected 0/1/0/0", flush_valid, stall_o, flush_set, reseed_done);
      end
      step();
      exp_seed = 12'h3C7;
      checks++;
      if (reseed_done !== 1'b1 || seed_o !== exp_seed || stall_o !== 1'b0) begin
         failures++;
         $display("FAIL basic_done: done=%b seed=%h stall=%b expected 1/%h/0", reseed_done, seed_o, stall_o, exp_seed);
      end
      step();
      checks++;
      if (reseed_done !== 1'b0) begin
         failures++;
         $display("FAIL done_pulse_width: done=%b expected 0", reseed_done);
      end
   endtask

   task automatic test_period();
      access_valid = 1'b1;
      for (int i = 0; i < 8; i++) begin
         checks++;
         if (stall_o !== 1'b0) begin
            failures++;
            $display("FAIL period_early access %0d: stall=%b expected 0", i, stall_o);
         end
         step();
      end
      checks++;
      if (stall_o !== 1'b1) begin
         failures++;
         $display("FAIL period_trigger: stall=%b expected 1", stall_o);
      end
      walk_flush("period");
      access_valid = 1'b0;
      prng_i = 12'h5A5;
      step();
      exp_seed = 12'h5A5;
      checks++;
      if (reseed_done !== 1'b1 || seed_o !== exp_seed) begin
         failures++;
         $display("FAIL period_done: done=%b seed=%h expected 1/%h", reseed_done, seed_o, exp_seed);
      end
      // Seven accesses must not trigger: the count restarted at zero.
      for (int i = 0; i < 7; i++) begin
         step();
         access_valid = 1'b1;
         checks++;
         if (stall_o !== 1'b0) begin
            failures++;
            $display("FAIL period_recount access %0d: stall=%b expected 0", i, stall_o);
         end
      end
      step();
      access_valid = 1'b0;
      repeat (3) step();
      checks++;
      if (stall_o !== 1'b0) begin
         failures++;
         $display("FAIL period_seven_no_trigger: stall=%b expected 0", stall_o);
      end
      access_valid = 1'b1;
      step();
      access_valid = 1'b0;
      checks++;
      if (stall_o !== 1'b1) begin
         failures++;
         $display("FAIL period_eighth_trigger: stall=%b expected 1", stall_o);
      end
      walk_flush("period2");
      prng_i = 12'h0F1;
      step();
      exp_seed = 12'h0F1;
      checks++;
      if (reseed_done !== 1'b1 || seed_o !== exp_seed) begin
         failures++;
         $display("FAIL period2_done: done=%b seed=%h expected 1/%h", reseed_done, seed_o, exp_seed);
      end
   endtask

   task automatic test_drain_handshake();
      int   ex;
      int   n;
      logic tog;
      step();
      mem_idle = 1'b0; reseed_req = 1'b1;
      step();
      reseed_req = 1'b0;
      for (int i = 0; i < 10; i++) begin
         checks++;
         if (stall_o !== 1'b1 || flush_valid !== 1'b0) begin
            failures++;
            $display("FAIL drain_hold cycle %0d: stall=%b fv=%b expected 1/0", i, stall_o, flush_valid);
         end
         step();
      end
      mem_idle = 1'b1;
      checks++;
      if (flush_valid !== 1'b0) begin
         failures++;
         $display("FAIL drain_release: fv=%b expected 0", flush_valid);
      end
      step();
      ex = 0; n = 0; tog = 1'b0;
      while (ex < 64 && n < 300) begin
         checks++;
         if (flush_valid !== 1'b1 || flush_set !== 6'(ex)) begin
            failures++;
            $display("FAIL handshake cycle %0d: valid=%b set=%0d expected valid=1 set=%0d", n, flush_valid, flush_set, ex);
         end
         flush_ready = tog;
         reseed_req  = (n == 40);
         if (tog) ex++;
         tog = ~tog;
         n++;
         step();
      end
      checks++;
      if (ex != 64) begin
         failures++;
         $display("FAIL handshake_timeout: accepted=%0d expected 64", ex);
      end
      reseed_req = 1'b0; flush_ready = 1'b1;
      prng_i = exp_seed;
      checks++;
      if (flush_valid !== 1'b0 || flush_set !== 6'd0) begin
         failures++;
         $display("FAIL handshake_swap: fv=%b set=%0d expected 0/0", flush_valid, flush_set);
      end
      step();
      exp_seed = exp_seed ^ 12'h001;
      checks++;
      if (reseed_done !== 1'b1 || seed_o !== exp_seed) begin
         failures++;
         $display("FAIL equal_seed_swap: done=%b seed=%h expected 1/%h", reseed_done, seed_o, exp_seed);
      end
      for (int i = 0; i < 5; i++) begin
         step();
         checks++;
         if (stall_o !== 1'b0 || reseed_done !== 1'b0) begin
            failures++;
            $display("FAIL coalesced_req cycle %0d: stall=%b done=%b expected 0/0", i, stall_o, reseed_done);
         end
      end
   endtask

   task automatic test_reset_mid_flush();
      mem_idle = 1'b1; flush_ready = 1'b1; reseed_req = 1'b1;
      step();
      reseed_req = 1'b0;
      step();
      repeat (17) step();
      checks++;
      if (flush_valid !== 1'b1 || flush_set !== 6'd17) begin
         failures++;
         $display("FAIL pre_abort: fv=%b set=%0d expected 1/17", flush_valid, flush_set);
      end
      reset = 1'b1;
      #1;
      checks++;
      if (flush_valid !== 1'b0 || stall_o !== 1'b0 || seed_o !== 12'hA5C || flush_set !== 6'd0) begin
         failures++;
         $display("FAIL async_abort: fv=%b stall=%b seed=%h set=%0d expected 0/0/a5c/0", flush_valid, stall_o, seed_o, flush_set);
      end
      #2;
      reset = 1'b0;
      step();
      step();
      checks++;
      if (flush_valid !== 1'b0 || stall_o !== 1'b0 || reseed_done !== 1'b0 || seed_o !== 12'hA5C) begin
         failures++;
         $display("FAIL post_abort_idle: fv=%b stall=%b done=%b seed=%h expected 0/0/0/a5c", flush_valid, stall_o, reseed_done, seed_o);
      end
   endtask

   initial begin
      test_reset();
      test_reseed_basic();
      test_period();
      test_drain_handshake();
      test_reset_mid_flush();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
